// File: rtl/ucsbece154a_memctl.sv
// ucsbece154a_memctl: load/store sequencer between the multi-cycle datapath
// and the unified word memory (synchronous write, combinational read).
// Handles byte/half/word loads with sign/zero extension. Sub-word stores are
// done as read-modify-write. Each accepted request gets exactly one response.
// Optional feature: define MEMCTL_ALIGN_TRAP_EN to fault on misaligned
// half/word accesses. When it is undefined, the misaligned low address bits
// are cleared and the access proceeds.
module ucsbece154a_memctl #(
  parameter logic [31:0] TEXT_START = 32'h00400000,
  parameter int unsigned TEXT_BYTES = 256,
  parameter logic [31:0] DATA_START = 32'h10000000,
  parameter int unsigned DATA_BYTES = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [1:0]  req_size_i,
  input  logic        req_unsigned_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  output logic        resp_valid_o,
  output logic [31:0] resp_rdata_o,
  output logic        resp_err_o,
  output logic [31:0] mem_a_o,
  output logic [31:0] mem_wd_o,
  output logic        mem_we_o,
  input  logic [31:0] mem_rd_i
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

  state_t state, state_next;

  logic [31:0] addr_q;
  logic [31:0] wd_q;
  logic [31:0] resp_rdata_q;
  logic [1:0]  size_q;
  logic        uns_q;
  logic        we_q;
  logic        resp_err_q;

  logic [31:0] eff_addr;
  logic [31:0] text_off;
  logic [31:0] data_off;
  logic [2:0]  req_bytes;
  logic        misaligned;
  logic        in_text;
  logic        in_data;
  logic        fault;
  logic        accept;

  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  logic [31:0] load_ext;
  logic [31:0] merged;

  assign accept = (state == IDLE) && req_valid_i;

  // Decode the incoming request: access width, effective address and fault check.
  // An access is legal only if every byte of it lies inside one region.
  always_comb begin
    req_bytes  = 3'd4;
    eff_addr   = req_addr_i;
    misaligned = 1'b0;
    case (req_size_i)
      2'b00:   req_bytes = 3'd1;
      2'b01:   req_bytes = 3'd2;
      default: req_bytes = 3'd4;
    endcase
`ifdef MEMCTL_ALIGN_TRAP_EN
    misaligned = ((req_size_i == 2'b01) && req_addr_i[0]) ||
                 ((req_size_i == 2'b10) && (req_addr_i[1:0] != 2'b00));
`else
    if (req_size_i == 2'b01) eff_addr[0] = 1'b0;
    if (req_size_i == 2'b10) eff_addr[1:0] = 2'b00;
`endif
    text_off = eff_addr - TEXT_START;
    data_off = eff_addr - DATA_START;
    in_text  = ({1'b0, text_off} + {30'd0, req_bytes}) <= 33'(TEXT_BYTES);
    in_data  = ({1'b0, data_off} + {30'd0, req_bytes}) <= 33'(DATA_BYTES);
    fault    = (req_size_i == 2'b11) || misaligned || !(in_text || in_data) ||
               (req_we_i && !in_data);
  end

  // Lane extraction for loads and lane replacement for sub-word stores (little-endian).
  always_comb begin
    lane_b   = mem_rd_i[{addr_q[1:0], 3'b000} +: 8];
    lane_h   = mem_rd_i[{addr_q[1], 4'b0000} +: 16];
    load_ext = mem_rd_i;
    merged   = mem_rd_i;
    case (size_q)
      2'b00: begin
        load_ext = {{24{lane_b[7] & ~uns_q}}, lane_b};
        merged[{addr_q[1:0], 3'b000} +: 8] = wd_q[7:0];
      end
      2'b01: begin
        load_ext = {{16{lane_h[15] & ~uns_q}}, lane_h};
        merged[{addr_q[1], 4'b0000} +: 16] = wd_q[15:0];
      end
      default: begin
        load_ext = mem_rd_i;
        merged   = wd_q;
      end
    endcase
  end

  // State register; reset from any state returns to IDLE.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic: faults respond at once, word stores skip the read phase.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (fault)                                state_next = RESP;
          else if (req_we_i && req_size_i == 2'b10) state_next = WRITE;
          else                                      state_next = READ;
        end
      end
      READ:    state_next = we_q ? WRITE : RESP;
      WRITE:   state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Request latch, read capture and response registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q       <= 32'd0;
      wd_q         <= 32'd0;
      size_q       <= 2'b00;
      uns_q        <= 1'b0;
      we_q         <= 1'b0;
      resp_rdata_q <= 32'd0;
      resp_err_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            addr_q       <= eff_addr;
            size_q       <= req_size_i;
            uns_q        <= req_unsigned_i;
            we_q         <= req_we_i;
            wd_q         <= req_wdata_i;
            resp_rdata_q <= 32'd0;
            resp_err_q   <= fault;
          end
        end
        READ: begin
          if (we_q) wd_q <= merged;
          else      resp_rdata_q <= load_ext;
        end
        RESP: begin
          resp_rdata_q <= 32'd0;
          resp_err_q   <= 1'b0;
        end
        default: begin
        end
      endcase
    end
  end

  assign req_ready_o  = (state == IDLE) && !reset;
  assign resp_valid_o = (state == RESP);
  assign resp_rdata_o = resp_rdata_q;
  assign resp_err_o   = resp_err_q;
  assign mem_a_o      = ((state == READ) || (state == WRITE)) ? {addr_q[31:2], 2'b00} : 32'd0;
  assign mem_we_o     = (state == WRITE) && !reset;
  assign mem_wd_o     = (state == WRITE) ? wd_q : 32'd0;

endmodule

// File: tb/tb_ucsbece154a_memctl.sv
// Testbench for ucsbece154a_memctl: directed scenarios plus randomized traffic.
// Expected responses and memory writes are queued at issue time from a
// byte-addressed reference model, and a negedge monitor checks them.
// Honors MEMCTL_ALIGN_TRAP_EN the same way as the design.
`timescale 1ns/1ps
module tb_ucsbece154a_memctl;

  localparam logic [31:0] TEXT_START = 32'h00400000;
  localparam logic [31:0] DATA_START = 32'h10000000;
  localparam longint TEXT_BASE = 64'h00400000;
  localparam longint DATA_BASE = 64'h10000000;
  localparam longint REGION_BYTES = 256;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid_i;
  logic        req_ready_o;
  logic        req_we_i;
  logic [1:0]  req_size_i;
  logic        req_unsigned_i;
  logic [31:0] req_addr_i;
  logic [31:0] req_wdata_i;
  logic        resp_valid_o;
  logic [31:0] resp_rdata_o;
  logic        resp_err_o;
  logic [31:0] mem_a_o;
  logic [31:0] mem_wd_o;
  logic        mem_we_o;
  logic [31:0] mem_rd_i;

  ucsbece154a_memctl dut (
    .clk(clk), .reset(reset),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_we_i(req_we_i), .req_size_i(req_size_i), .req_unsigned_i(req_unsigned_i),
    .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
    .resp_valid_o(resp_valid_o), .resp_rdata_o(resp_rdata_o), .resp_err_o(resp_err_o),
    .mem_a_o(mem_a_o), .mem_wd_o(mem_wd_o), .mem_we_o(mem_we_o), .mem_rd_i(mem_rd_i)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] rdata; logic err; int due; } resp_exp_t;
  typedef struct { logic [31:0] addr; logic [31:0] data; int due; } wr_exp_t;

  resp_exp_t resp_q[$];
  wr_exp_t   wr_q[$];
  resp_exp_t re;
  wr_exp_t   we_e;

  int vectors = 0;
  int miscompares = 0;
  int neg_cnt = 0;

  logic [31:0] dmem [64];
  logic [7:0]  ref_data [256];
  logic        mem_init;
  logic [31:0] t_off;
  logic [31:0] d_off;

  // Deterministic initial memory image shared by the memory model and the reference model.
  function automatic logic [31:0] init_word(input logic is_text, input logic [5:0] idx);
    return (({26'd0, idx} + 32'd1) * 32'h9E3779B9) ^ (is_text ? 32'h5A5A1234 : 32'hC3A50F0F);
  endfunction

  function automatic logic [7:0] byte_at(input longint a);
    logic [31:0] w;
    if (a >= TEXT_BASE && a < TEXT_BASE + REGION_BYTES) begin
      w = init_word(1'b1, 6'((a - TEXT_BASE) >> 2));
      return w[8*int'((a - TEXT_BASE) % 4) +: 8];
    end
    return ref_data[int'(a - DATA_BASE)];
  endfunction

  assign t_off = mem_a_o - TEXT_START;
  assign d_off = mem_a_o - DATA_START;

  // Unified memory: combinational read, text is read-only.
  always_comb begin
    mem_rd_i = 32'd0;
    if (t_off < 32'd256)      mem_rd_i = init_word(1'b1, t_off[7:2]);
    else if (d_off < 32'd256) mem_rd_i = dmem[d_off[7:2]];
  end

  // Synchronous write port of the data region, preloaded while mem_init is high.
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 64; i++) dmem[i] <= init_word(1'b0, 6'(i));
    end else if (mem_we_o && d_off < 32'd256) begin
      dmem[d_off[7:2]] <= mem_wd_o;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, required %h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Monitor: pops expectations when the DUT responds or writes, and flags overdue ones.
  always @(negedge clk) begin
    neg_cnt = neg_cnt + 1;
    if (resp_valid_o) begin
      if (resp_q.size() == 0) begin
        checkOutput("unexpected_resp", 32'd1, 32'd0);
      end else begin
        re = resp_q.pop_front();
        checkOutput("resp_rdata", resp_rdata_o, re.rdata);
        checkOutput("resp_err", {31'd0, resp_err_o}, {31'd0, re.err});
        checkOutput("resp_latency", 32'(neg_cnt), 32'(re.due));
        checkOutput("ready_in_resp", {31'd0, req_ready_o}, 32'd0);
      end
    end
    if (resp_q.size() != 0 && neg_cnt > resp_q[0].due) begin
      re = resp_q.pop_front();
      checkOutput("missing_resp", 32'd0, 32'd1);
    end
    if (mem_we_o) begin
      if (wr_q.size() == 0) begin
        checkOutput("unexpected_write", mem_a_o, 32'hFFFFFFFF);
      end else begin
        we_e = wr_q.pop_front();
        checkOutput("write_addr", mem_a_o, we_e.addr);
        checkOutput("write_data", mem_wd_o, we_e.data);
        checkOutput("write_time", 32'(neg_cnt), 32'(we_e.due));
      end
    end
    if (wr_q.size() != 0 && neg_cnt > wr_q[0].due) begin
      we_e = wr_q.pop_front();
      checkOutput("missing_write", 32'd0, 32'd1);
    end
  end

  task automatic waitReady(output logic ok);
    int waited;
    waited = 0;
    do begin
      @(negedge clk);
      #1;
      waited++;
    end while (!req_ready_o && waited < 50);
    ok = req_ready_o;
    if (!ok) checkOutput("ready_timeout", {31'd0, req_ready_o}, 32'd1);
  endtask

  // Issue one request and queue the response/write the reference model predicts.
  task automatic applyStimulus(input logic we, input logic [1:0] size, input logic uns,
                               input logic [31:0] addr, input logic [31:0] wdata);
    logic ok;
    longint a;
    longint nb;
    logic err;
    logic in_text;
    logic in_data;
    logic [63:0] val;
    logic [31:0] wa;
    int o;
    int lat;
    resp_exp_t r;
    wr_exp_t w;
    waitReady(ok);
    if (!ok) return;
    nb  = (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
    a   = longint'(addr);
    err = 1'b0;
    val = 64'd0;
    if (size == 2'b11) begin
      err = 1'b1;
    end else begin
`ifdef MEMCTL_ALIGN_TRAP_EN
      if (a % nb != 0) err = 1'b1;
`else
      a = a - (a % nb);
`endif
      in_text = (a >= TEXT_BASE) && (a + nb <= TEXT_BASE + REGION_BYTES);
      in_data = (a >= DATA_BASE) && (a + nb <= DATA_BASE + REGION_BYTES);
      if (!in_text && !in_data) err = 1'b1;
      if (we && !in_data) err = 1'b1;
    end
    r.err = err;
    r.rdata = 32'd0;
    if (err) begin
      lat = 1;
    end else if (!we) begin
      for (int i = 0; i < int'(nb); i++) val = val | (64'(byte_at(a + i)) << (8 * i));
      if (!uns && nb < 4 && val[8*int'(nb)-1]) val = val - (64'd1 << (8 * int'(nb)));
      r.rdata = val[31:0];
      lat = 2;
    end else begin
      o = int'(a - DATA_BASE);
      for (int i = 0; i < int'(nb); i++) ref_data[o + i] = wdata[8*i +: 8];
      wa = 32'(a) & ~32'd3;
      o  = int'(wa - DATA_START);
      w.addr = wa;
      w.data = {ref_data[o+3], ref_data[o+2], ref_data[o+1], ref_data[o]};
      lat = (nb == 4) ? 2 : 3;
      w.due = neg_cnt + lat - 1;
      wr_q.push_back(w);
    end
    r.due = neg_cnt + lat;
    resp_q.push_back(r);
    req_valid_i    = 1'b1;
    req_we_i       = we;
    req_size_i     = size;
    req_unsigned_i = uns;
    req_addr_i     = addr;
    req_wdata_i    = wdata;
    @(posedge clk);
    #1;
    req_valid_i = 1'b0;
  endtask

  // Sub-word store interrupted by reset in its write phase: no write, no response.
  task automatic applyResetMidRmw(input logic [31:0] addr, input logic [31:0] wdata);
    logic ok;
    waitReady(ok);
    if (!ok) return;
    req_valid_i = 1'b1; req_we_i = 1'b1; req_size_i = 2'b00; req_unsigned_i = 1'b0;
    req_addr_i = addr; req_wdata_i = wdata;
    @(posedge clk);
    #1;
    req_valid_i = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("rmw_in_write", {31'd0, mem_we_o}, 32'd1);
    reset = 1'b1;
    #1;
    checkOutput("rmw_reset_we", {31'd0, mem_we_o}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    #1;
    reset = 1'b0;
    #1;
    checkOutput("rmw_ready_after", {31'd0, req_ready_o}, 32'd1);
    checkOutput("rmw_no_resp", {31'd0, resp_valid_o}, 32'd0);
  endtask

  logic [31:0] ra;
  logic [31:0] exp_w;
  int drain;

  initial begin
    reset = 1'b1; mem_init = 1'b1;
    req_valid_i = 1'b0; req_we_i = 1'b0; req_size_i = 2'b00; req_unsigned_i = 1'b0;
    req_addr_i = 32'd0; req_wdata_i = 32'd0;
    for (int i = 0; i < 256; i++) begin
      exp_w = init_word(1'b0, 6'(i / 4));
      ref_data[i] = exp_w[8*(i%4) +: 8];
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    mem_init = 1'b0;
    #1;
    $display("[TB] checking reset state");
    checkOutput("rst_resp_valid", {31'd0, resp_valid_o}, 32'd0);
    checkOutput("rst_resp_err", {31'd0, resp_err_o}, 32'd0);
    checkOutput("rst_resp_rdata", resp_rdata_o, 32'd0);
    checkOutput("rst_mem_we", {31'd0, mem_we_o}, 32'd0);
    checkOutput("rst_mem_a", mem_a_o, 32'd0);
    checkOutput("rst_mem_wd", mem_wd_o, 32'd0);
    checkOutput("rst_ready_low", {31'd0, req_ready_o}, 32'd0);
    reset = 1'b0;
    #1;
    checkOutput("rst_ready_high", {31'd0, req_ready_o}, 32'd1);

    $display("[TB] directed scenarios");
    applyStimulus(1'b1, 2'b10, 1'b0, 32'h10000004, 32'hDEADBEEF);
    applyStimulus(1'b0, 2'b10, 1'b0, 32'h10000004, 32'd0);
    applyStimulus(1'b1, 2'b10, 1'b0, 32'h10000008, 32'h11223344);
    applyStimulus(1'b1, 2'b00, 1'b0, 32'h1000000A, 32'h000000AA);
    applyStimulus(1'b0, 2'b00, 1'b1, 32'h1000000A, 32'd0);
    applyStimulus(1'b0, 2'b00, 1'b0, 32'h1000000A, 32'd0);
    applyStimulus(1'b1, 2'b10, 1'b0, 32'h10000010, 32'h80017F02);
    applyStimulus(1'b0, 2'b01, 1'b0, 32'h10000012, 32'd0);
    applyStimulus(1'b0, 2'b01, 1'b1, 32'h10000012, 32'd0);
    applyStimulus(1'b0, 2'b01, 1'b0, 32'h10000010, 32'd0);
    applyStimulus(1'b1, 2'b10, 1'b0, 32'h00400000, 32'h12345678);
    applyStimulus(1'b0, 2'b10, 1'b0, 32'h10000100, 32'd0);
    applyStimulus(1'b0, 2'b10, 1'b0, 32'h00400000, 32'd0);
    applyStimulus(1'b1, 2'b01, 1'b0, 32'h10000001, 32'h00005566);
    applyStimulus(1'b0, 2'b10, 1'b0, 32'h10000000, 32'd0);
    applyResetMidRmw(32'h10000009, 32'h00000077);
    applyStimulus(1'b0, 2'b10, 1'b0, 32'h10000008, 32'd0);
    applyStimulus(1'b0, 2'b10, 1'b0, 32'h100000FC, 32'd0);
    applyStimulus(1'b0, 2'b01, 1'b0, 32'h100000FF, 32'd0);
    applyStimulus(1'b0, 2'b00, 1'b0, 32'h100000FF, 32'd0);
    applyStimulus(1'b0, 2'b00, 1'b1, 32'h004000FF, 32'd0);
    applyStimulus(1'b0, 2'b00, 1'b0, 32'h003FFFFF, 32'd0);
    applyStimulus(1'b0, 2'b11, 1'b0, 32'h10000020, 32'd0);
    applyStimulus(1'b1, 2'b10, 1'b0, 32'h100000FE, 32'hCAFEF00D);

    $display("[TB] random traffic");
    for (int n = 0; n < 300; n++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4, 5: ra = DATA_START + $urandom_range(0, 255);
        6:                ra = DATA_START + $urandom_range(250, 262);
        7:                ra = TEXT_START + $urandom_range(0, 255);
        8:                ra = TEXT_START + $urandom_range(0, 262) - 32'd3;
        default:          ra = $urandom;
      endcase
      applyStimulus(1'($urandom_range(0, 1)),
                    ($urandom_range(0, 7) == 0) ? 2'b11 : 2'($urandom_range(0, 2)),
                    1'($urandom_range(0, 1)), ra, $urandom);
    end

    drain = 0;
    while ((resp_q.size() != 0 || wr_q.size() != 0) && drain < 20) begin
      @(negedge clk);
      drain++;
    end
    #1;
    checkOutput("resp_queue_drained", 32'(resp_q.size()), 32'd0);
    checkOutput("write_queue_drained", 32'(wr_q.size()), 32'd0);
    for (int i = 0; i < 64; i++) begin
      exp_w = {ref_data[4*i+3], ref_data[4*i+2], ref_data[4*i+1], ref_data[4*i]};
      checkOutput("final_data_word", dmem[i], exp_w);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
